// File: rtl/ram_uart_defs.sv
// Shared definitions for the RAM <-> PC UART paths.
// Holds address width, baud divider and FSM state encodings.
package ram_uart_defs;

  localparam int ADDR_W   = 16;
  localparam int CLK_HZ   = 100_000_000;
  localparam int BAUD     = 115200;
  localparam int BAUD_DIV = CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/recv_pc_to_ram32_uart_rx.sv
// 8N1 UART receiver: 2-flop sync, edge start detect,
// half-bit start recheck, mid-bit sampling, stop-bit check.
module uart_rx
  import ram_uart_defs::*;
#(
  parameter int DIV = BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

  logic [1:0]    sync;
  logic          prev;
  logic          rx_s;
  rx_state_t     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          done_n;

  assign rx_s    = sync[1];
  assign rx_data = sh;

  // Synchronizer, edge history and receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      prev    <= 1'b1;
      st      <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      rx_done <= 1'b0;
    end else begin
      sync    <= {sync[0], rs232_rx};
      prev    <= rx_s;
      st      <= st_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      rx_done <= done_n;
    end
  end

  // Bit timing and next-state decode
  always_comb begin
    st_n   = st;
    cnt_n  = cnt + 1'b1;
    idx_n  = idx;
    sh_n   = sh;
    done_n = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (prev && !rx_s) st_n = RX_START;
      end
      RX_START: begin
        if (cnt == MID) begin
          cnt_n = '0;
          st_n  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 1'b1;
          if (idx == 3'd7) st_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          cnt_n  = '0;
          st_n   = RX_IDLE;
          done_n = rx_s;
        end
      end
      default: st_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/recv_pc_to_ram32.sv
// PC -> RAM word loader: 4 UART bytes (LSB first) per 32-bit word.
// RECV_TIMEOUT_EN enables an inter-byte timeout that pulses err.
module recv_pc_to_ram32
  import ram_uart_defs::*;
#(
  parameter int CLK_HZ = ram_uart_defs::CLK_HZ,
  parameter int BAUD   = ram_uart_defs::BAUD
`ifdef RECV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 10_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              recv_sig,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              rs232_rx,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              ok,
  output logic              err
);

  logic [7:0]        rx_data;
  logic              rx_done;
  xfer_state_t       state, state_n;
  logic [ADDR_W-1:0] addr_n, end_q, end_n;
  logic [31:0]       wdata_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic              tmo;

  uart_rx #(.DIV(CLK_HZ / BAUD)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rs232_rx (rs232_rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

`ifdef RECV_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Idle-line counter, restarted by each accepted start and each byte
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (rx_done || (state == IDLE && recv_sig)) begin
      tmo_cnt <= '0;
    end else if (state == RECV) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (state == RECV) && !rx_done &&
               (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign write = (state == WRITE);
  assign ok    = (state == DONE);
  assign busy  = (state != IDLE);
  assign err   = tmo;

  // Transfer state, address, data and byte count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      end_q    <= '0;
      wdata    <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      end_q    <= end_n;
      wdata    <= wdata_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  // Word assembly and address sequencing
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    end_n      = end_q;
    wdata_n    = wdata;
    byte_cnt_n = byte_cnt;
    unique case (state)
      IDLE: begin
        if (recv_sig) begin
          addr_n     = start_addr;
          end_n      = end_addr;
          byte_cnt_n = '0;
          state_n    = RECV;
        end
      end
      RECV: begin
        if (rx_done) begin
          wdata_n    = {rx_data, wdata[31:8]};
          byte_cnt_n = byte_cnt + 1'b1;
          if (byte_cnt == 2'd3) state_n = WRITE;
        end else if (tmo) begin
          state_n = IDLE;
        end
      end
      WRITE: begin
        if (addr == end_q) begin
          state_n = DONE;
        end else begin
          addr_n     = addr + 1'b1;
          byte_cnt_n = '0;
          state_n    = RECV;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_recv_pc_to_ram32.sv
// Directed bench for recv_pc_to_ram32 with a fast baud divider.
// UART driver feeds bytes; a RAM model logs every write.
module tb_recv_pc_to_ram32;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recv_sig = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic        rs232_rx = 1'b1;
  logic        write;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ok;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ok_n = 0;
  int err_n = 0;
  int ok_cyc = 0;
  int w_cyc = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];

  recv_pc_to_ram32 #(
    .CLK_HZ (1_600_000),
    .BAUD   (100_000)
`ifdef RECV_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (50000)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .recv_sig   (recv_sig),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rs232_rx   (rs232_rx),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .ok         (ok),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write) begin
      wa.push_back(addr);
      wd.push_back(wdata);
      w_cyc = cyc;
    end
    if (ok) begin
      ok_n++;
      ok_cyc = cyc;
    end
    if (err) err_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tx(input logic [7:0] b, input logic stop = 1'b1);
    rs232_rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rs232_rx = stop;
    repeat (DIV) @(posedge clk);
    rs232_rx = 1'b1;
    repeat (DIV) @(posedge clk);
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] e);
    @(negedge clk);
    start_addr = s;
    end_addr   = e;
    recv_sig   = 1'b1;
    @(negedge clk);
    recv_sig   = 1'b0;
  endtask

  task automatic wait_ok(input string tag, input int n0);
    for (int i = 0; i < 400 && ok_n == n0; i++) @(negedge clk);
    chk(tag, ok_n, n0 + 1);
  endtask

  function automatic logic [31:0] wa_at(input int i);
    return (i < wa.size()) ? 32'(wa[i]) : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    return (i < wd.size()) ? wd[i] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    int n0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", ok, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);

    // single word, start == end
    wa.delete(); wd.delete(); n0 = ok_n;
    go(16'h0010, 16'h0010);
    chk("t1_busy", busy, 1);
    tx(8'h78); tx(8'h56); tx(8'h34); tx(8'h12);
    wait_ok("t1_ok", n0);
    chk("t1_nwr", wa.size(), 1);
    chk("t1_addr", wa_at(0), 32'h0010);
    chk("t1_data", wd_at(0), 32'h1234_5678);
    chk("t1_ok_gap", ok_cyc - w_cyc, 1);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // three words, ascending bytes
    wa.delete(); wd.delete(); n0 = ok_n;
    go(16'h0000, 16'h0002);
    for (int i = 0; i < 12; i++) tx(8'(i));
    wait_ok("t2_ok", n0);
    chk("t2_nwr", wa.size(), 3);
    chk("t2_a0", wa_at(0), 32'h0000);
    chk("t2_d0", wd_at(0), 32'h0302_0100);
    chk("t2_a1", wa_at(1), 32'h0001);
    chk("t2_d1", wd_at(1), 32'h0706_0504);
    chk("t2_a2", wa_at(2), 32'h0002);
    chk("t2_d2", wd_at(2), 32'h0B0A_0908);
    repeat (50) @(negedge clk);
    chk("t2_one_ok", ok_n, n0 + 1);

    // address wrap 0xFFFF -> 0x0000
    wa.delete(); wd.delete(); n0 = ok_n;
    go(16'hFFFF, 16'h0000);
    for (int i = 0; i < 8; i++) tx(8'(8'h10 + i));
    wait_ok("t3_ok", n0);
    repeat (50) @(negedge clk);
    chk("t3_nwr", wa.size(), 2);
    chk("t3_a0", wa_at(0), 32'hFFFF);
    chk("t3_d0", wd_at(0), 32'h1312_1110);
    chk("t3_a1", wa_at(1), 32'h0000);
    chk("t3_d1", wd_at(1), 32'h1716_1514);

    // bytes while idle, then recv_sig while busy
    wa.delete(); wd.delete(); n0 = ok_n;
    tx(8'h55); tx(8'h66);
    chk("t4_idle_nwr", wa.size(), 0);
    chk("t4_idle_busy", busy, 0);
    go(16'h0100, 16'h0101);
    tx(8'hA0); tx(8'hA1);
    go(16'h0200, 16'h0200);
    for (int i = 2; i < 8; i++) tx(8'(8'hA0 + i));
    wait_ok("t4_ok", n0);
    chk("t4_nwr", wa.size(), 2);
    chk("t4_a0", wa_at(0), 32'h0100);
    chk("t4_d0", wd_at(0), 32'hA3A2_A1A0);
    chk("t4_a1", wa_at(1), 32'h0101);
    chk("t4_d1", wd_at(1), 32'hA7A6_A5A4);

    // bad stop bit dropped
    wa.delete(); wd.delete(); n0 = ok_n;
    go(16'h0020, 16'h0020);
    tx(8'hEE, 1'b0);
    tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h44);
    wait_ok("t5_ok", n0);
    chk("t5_nwr", wa.size(), 1);
    chk("t5_addr", wa_at(0), 32'h0020);
    chk("t5_data", wd_at(0), 32'h4433_2211);

    // reset mid-word
    wa.delete(); wd.delete();
    go(16'h0030, 16'h0030);
    tx(8'hC1); tx(8'hC2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", addr, 0);
    chk("t5_rst_wdata", wdata, 0);
    repeat (20) @(negedge clk);
    chk("t5_rst_nwr", wa.size(), 0);

    // silence after two bytes
    wa.delete(); wd.delete(); n0 = err_n;
    go(16'h0040, 16'h0040);
    tx(8'hD1); tx(8'hD2);
`ifdef RECV_TIMEOUT_EN
    for (int i = 0; i < 60000 && err_n == n0; i++) @(negedge clk);
    chk("t6_err", err_n, n0 + 1);
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_nwr", wa.size(), 0);
`else
    repeat (3000) @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_err", err_n, n0);
    chk("t6_nwr", wa.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
